// File: rtl/dot_product_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_pkg
// Shared definitions for the dot-product engine: FSM state encoding, the
// pipeline depth, and a small constant helper used when sizing datapaths.
// No ports.
// -----------------------------------------------------------------------------
package dot_product_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dp_state_t;

    // bank read -> lane products -> lane sum -> accumulator
    localparam int PIPE = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// -----------------------------------------------------------------------------
// dot_product_engine_if
// Bundles the load, command and status signals of the dot-product engine.
//   master : drives load_en/load_addr/load_a/load_b, start/len/acc_mode/acc_init;
//            observes busy/done/result/overflow/state
//   slave  : the engine side (directions reversed)
// -----------------------------------------------------------------------------
interface dot_product_engine_if
    import dot_product_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int LANES  = 2,
    parameter int DW_IN  = 8,
    parameter int DW_OUT = 16
) ();

    logic                     load_en;
    logic [ADDR_W-1:0]        load_addr;
    logic [LANES*DW_IN-1:0]   load_a;
    logic [LANES*DW_IN-1:0]   load_b;
    logic                     start;
    logic [ADDR_W:0]          len;
    logic                     acc_mode;
    logic [DW_OUT-1:0]        acc_init;
    logic                     busy;
    logic                     done;
    logic [DW_OUT-1:0]        result;
    logic                     overflow;
    dp_state_t                state;

    modport master (
        output load_en, load_addr, load_a, load_b, start, len, acc_mode, acc_init,
        input  busy, done, result, overflow, state
    );

    modport slave (
        input  load_en, load_addr, load_a, load_b, start, len, acc_mode, acc_init,
        output busy, done, result, overflow, state
    );

endinterface

// File: rtl/dp_bank.sv
// -----------------------------------------------------------------------------
// dp_bank
// One operand bank: simple dual-port RAM, one write port and one synchronous
// read port with a single cycle of read latency. Contents are never reset.
//   clk     : rising-edge clock
//   we      : write enable
//   wr_addr : write word address
//   wr_data : write word
//   rd_addr : read word address
//   rd_data : registered read word (valid one cycle after rd_addr)
// -----------------------------------------------------------------------------
module dp_bank #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
// Streams len words from two operand banks through a 4-stage pipeline
// (bank read, per-lane products, lane sum, saturating accumulate) and reports
// the saturated dot product.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (banks are not cleared)
//   bus   : dot_product_engine_if.slave -- load port, start/len/acc_mode/
//           acc_init command, busy/done/result/overflow/state status
// -----------------------------------------------------------------------------
module dot_product_engine
    import dot_product_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int LANES  = 2,
    parameter int DW_IN  = 8,
    parameter int DW_OUT = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dot_product_engine_if.slave  bus
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WORD_W = LANES * DW_IN;
    localparam int PW     = 2 * DW_IN;
    localparam int SW     = PW + $clog2(LANES);
    localparam int AW     = max_int(DW_OUT, SW) + 2;   // headroom so acc+sum never wraps
    localparam int CW     = ADDR_W + 2;

    localparam logic [ADDR_W:0]        LEN_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic signed [AW-1:0]   SAT_MAX   = SIGNED ? AW'({1'b0, {(DW_OUT-1){1'b1}}})
                                                          : AW'({DW_OUT{1'b1}});
    localparam logic signed [AW-1:0]   SAT_MIN   = SIGNED ? ~AW'({1'b0, {(DW_OUT-1){1'b1}}})
                                                          : '0;

    dp_state_t           state_reg, state_next;
    logic [ADDR_W:0]     remaining_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [CW-1:0]       cnt_reg;
    logic [ADDR_W:0]     len_c;
    logic                busy, accept, issue;

    logic [WORD_W-1:0]   a_word, b_word;
    logic                v1_reg, v2_reg, v3_reg;
    logic [PW-1:0]       prod_next [LANES];
    logic [PW-1:0]       prod_reg  [LANES];
    logic [SW-1:0]       sum_next, sum_reg;

    logic signed [AW-1:0] acc_ext, sum_ext, acc_sum;
    logic [DW_OUT-1:0]   acc_sat, acc_reg, result_reg;
    logic                clamp, overflow_reg;

    assign busy   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign accept = (state_reg == ST_IDLE) && bus.start;
    assign issue  = (state_reg == ST_RUN) && (remaining_reg != '0);
    assign len_c  = (bus.len > LEN_DEPTH) ? LEN_DEPTH : bus.len;

    dp_bank #(.ADDR_W(ADDR_W), .WIDTH(WORD_W)) bank_a (
        .clk(clk), .we(bus.load_en && !busy), .wr_addr(bus.load_addr),
        .wr_data(bus.load_a), .rd_addr(rd_addr_reg), .rd_data(a_word)
    );

    dp_bank #(.ADDR_W(ADDR_W), .WIDTH(WORD_W)) bank_b (
        .clk(clk), .we(bus.load_en && !busy), .wr_addr(bus.load_addr),
        .wr_data(bus.load_b), .rd_addr(rd_addr_reg), .rd_data(b_word)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_RUN;
            ST_RUN:   if (remaining_reg <= (ADDR_W+1)'(1)) state_next = ST_DRAIN;
            ST_DRAIN: if (cnt_reg == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // cnt_reg counts down the whole operation (len + PIPE - 1 cycles after
    // acceptance). For len>0 it reaches zero exactly as the pipeline empties;
    // for len=0 it keeps the fixed PIPE-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            rd_addr_reg   <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                remaining_reg <= len_c;
                rd_addr_reg   <= '0;
                cnt_reg       <= CW'(len_c) + CW'(PIPE - 1);
            end else begin
                if (issue) begin
                    remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
                    rd_addr_reg   <= rd_addr_reg + ADDR_W'(1);
                end
                if (busy && cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------- datapath
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW_IN-1:0] a_el, b_el;
            logic [PW-1:0]    a_ext, b_ext;
            assign a_el = a_word[gi*DW_IN +: DW_IN];
            assign b_el = b_word[gi*DW_IN +: DW_IN];
            if (SIGNED) begin : g_sext
                assign a_ext = PW'($signed(a_el));
                assign b_ext = PW'($signed(b_el));
            end else begin : g_zext
                assign a_ext = PW'(a_el);
                assign b_ext = PW'(b_el);
            end
            // low PW bits of the extended product are exact in both modes
            assign prod_next[gi] = a_ext * b_ext;
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < LANES; k++) begin
            if (SIGNED) sum_next = sum_next + SW'($signed(prod_reg[k]));
            else        sum_next = sum_next + SW'(prod_reg[k]);
        end
    end

    always_comb begin
        if (SIGNED) begin
            acc_ext = AW'($signed(acc_reg));
            sum_ext = AW'($signed(sum_reg));
        end else begin
            acc_ext = AW'(acc_reg);
            sum_ext = AW'(sum_reg);
        end
        acc_sum = acc_ext + sum_ext;
        clamp   = 1'b0;
        acc_sat = acc_sum[DW_OUT-1:0];
        if (acc_sum > SAT_MAX) begin
            acc_sat = SAT_MAX[DW_OUT-1:0];
            clamp   = 1'b1;
        end else if (acc_sum < SAT_MIN) begin
            acc_sat = SAT_MIN[DW_OUT-1:0];
            clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            v3_reg       <= 1'b0;
            sum_reg      <= '0;
            acc_reg      <= '0;
            overflow_reg <= 1'b0;
            result_reg   <= '0;
            for (int k = 0; k < LANES; k++) prod_reg[k] <= '0;
        end else begin
            v1_reg  <= issue;
            v2_reg  <= v1_reg;
            v3_reg  <= v2_reg;
            sum_reg <= sum_next;
            for (int k = 0; k < LANES; k++) prod_reg[k] <= prod_next[k];
            if (accept) begin
                acc_reg      <= bus.acc_mode ? bus.acc_init : '0;
                overflow_reg <= 1'b0;
            end else if (v3_reg && !overflow_reg) begin
                // once clamped the accumulator is frozen at the limit
                acc_reg <= acc_sat;
                if (clamp) overflow_reg <= 1'b1;
            end
            if (state_reg == ST_DRAIN && cnt_reg == '0) begin
                result_reg <= acc_reg;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.result   = result_reg;
    assign bus.overflow = overflow_reg;
    assign bus.state    = state_reg;

endmodule

// File: tb/tb_dot_product_engine.sv
module tb_dot_product_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference copy of the operand banks (raw element bytes)
    logic [7:0] ma [16][2];
    logic [7:0] mb [16][2];

    dot_product_engine_if #(.ADDR_W(4), .LANES(2), .DW_IN(8), .DW_OUT(16)) bus_u ();
    dot_product_engine_if #(.ADDR_W(4), .LANES(2), .DW_IN(8), .DW_OUT(16)) bus_s ();

    // the signed engine sees exactly the same stimulus as the unsigned one
    assign bus_s.load_en   = bus_u.load_en;
    assign bus_s.load_addr = bus_u.load_addr;
    assign bus_s.load_a    = bus_u.load_a;
    assign bus_s.load_b    = bus_u.load_b;
    assign bus_s.start     = bus_u.start;
    assign bus_s.len       = bus_u.len;
    assign bus_s.acc_mode  = bus_u.acc_mode;
    assign bus_s.acc_init  = bus_u.acc_init;

    dot_product_engine #(.ADDR_W(4), .LANES(2), .DW_IN(8), .DW_OUT(16), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_u)
    );

    dot_product_engine #(.ADDR_W(4), .LANES(2), .DW_IN(8), .DW_OUT(16), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // dot product by plain integer arithmetic with a clamp that sticks
    function automatic void model(input bit sgn, input int len, input bit mode,
                                  input logic [15:0] init,
                                  output logic [15:0] res, output bit ovf);
        longint acc, mx, mn, s, ea, eb;
        int n;
        n   = (len > 16) ? 16 : len;
        mx  = sgn ? 32767 : 65535;
        mn  = sgn ? -32768 : 0;
        acc = mode ? (sgn ? longint'($signed(init)) : longint'(init)) : 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = 0;
            for (int k = 0; k < 2; k++) begin
                ea = sgn ? longint'($signed(ma[i][k])) : longint'(ma[i][k]);
                eb = sgn ? longint'($signed(mb[i][k])) : longint'(mb[i][k]);
                s += ea * eb;
            end
            if (!ovf) begin
                acc += s;
                if (acc > mx) begin acc = mx; ovf = 1'b1; end
                else if (acc < mn) begin acc = mn; ovf = 1'b1; end
            end
        end
        res = acc[15:0];
    endfunction

    task automatic load_word(input int addr, input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk);
        bus_u.load_en   = 1'b1;
        bus_u.load_addr = addr[3:0];
        bus_u.load_a    = {a1, a0};
        bus_u.load_b    = {b1, b0};
        @(posedge clk);
        #1;
        bus_u.load_en = 1'b0;
        ma[addr][0] = a0; ma[addr][1] = a1;
        mb[addr][0] = b0; mb[addr][1] = b1;
    endtask

    task automatic rand_fill(input int maxv);
        for (int i = 0; i < 16; i++) begin
            load_word(i, 8'($urandom_range(0, maxv)), 8'($urandom_range(0, maxv)),
                         8'($urandom_range(0, maxv)), 8'($urandom_range(0, maxv)));
        end
    endtask

    task automatic run_op(input string tag, input int len, input bit mode, input logic [15:0] init,
                          input bit perturb,
                          output logic [15:0] ru, output logic [15:0] rs,
                          output bit ou, output bit os);
        logic [15:0] eu, es;
        bit eou, eos;
        int lat, n;
        model(1'b0, len, mode, init, eu, eou);
        model(1'b1, len, mode, init, es, eos);
        n = (len > 16) ? 16 : len;
        @(negedge clk);
        bus_u.start    = 1'b1;
        bus_u.len      = 5'(len);
        bus_u.acc_mode = mode;
        bus_u.acc_init = init;
        @(posedge clk);
        #1;
        bus_u.start = 1'b0;
        check_val({tag, "_busy"}, longint'(bus_u.busy), 1);
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            bus_u.start   = 1'b0;
            bus_u.load_en = 1'b0;
            if (bus_u.done) begin
                lat = k;
            end else if (perturb && k == 2) begin
                bus_u.start     = 1'b1;
                bus_u.len       = 5'd3;
                bus_u.load_en   = 1'b1;
                bus_u.load_addr = 4'd0;
                bus_u.load_a    = {~ma[0][1], ~ma[0][0]};
                bus_u.load_b    = {~mb[0][1], ~mb[0][0]};
            end
        end
        ru = bus_u.result; rs = bus_s.result;
        ou = bus_u.overflow; os = bus_s.overflow;
        check_val({tag, "_latency"}, lat, n + 4);
        check_val({tag, "_done_s"}, longint'(bus_s.done), 1);
        check_val({tag, "_busy_at_done"}, longint'(bus_u.busy), 0);
        check_val({tag, "_result_u"}, longint'(ru), longint'(eu));
        check_val({tag, "_ovf_u"}, longint'(ou), longint'(eou));
        check_val({tag, "_result_s"}, longint'(rs), longint'(es));
        check_val({tag, "_ovf_s"}, longint'(os), longint'(eos));
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, longint'(bus_u.done), 0);
        check_val({tag, "_state_idle"}, longint'(bus_u.state), 0);
        $display("op %s len=%0d mode=%0d init=%0d lat=%0d unsigned=%0d/%0d signed=%0d/%0d",
                 tag, len, mode, init, lat, ru, ou, $signed(rs), os);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ru, rs;
        bit ou, os;
        int seen;

        bus_u.load_en = 1'b0; bus_u.load_addr = '0; bus_u.load_a = '0; bus_u.load_b = '0;
        bus_u.start = 1'b0; bus_u.len = '0; bus_u.acc_mode = 1'b0; bus_u.acc_init = '0;

        repeat (3) @(negedge clk);
        check_val("rst_state",    longint'(bus_u.state), 0);
        check_val("rst_busy",     longint'(bus_u.busy), 0);
        check_val("rst_done",     longint'(bus_u.done), 0);
        check_val("rst_result",   longint'(bus_u.result), 0);
        check_val("rst_overflow", longint'(bus_u.overflow), 0);
        check_val("rst_result_s", longint'(bus_s.result), 0);
        rst_n = 1'b1;

        // ramp A = 1..32, B = 1
        for (int i = 0; i < 16; i++) load_word(i, 8'(2*i+1), 8'(2*i+2), 8'd1, 8'd1);
        run_op("ramp", 16, 1'b0, 16'd0, 1'b0, ru, rs, ou, os);
        check_val("ramp_const", longint'(ru), 528);
        check_val("ramp_const_ovf", longint'(ou), 0);

        // A = 2, B = 3, preset accumulator
        for (int i = 0; i < 16; i++) load_word(i, 8'd2, 8'd2, 8'd3, 8'd3);
        run_op("preset", 4, 1'b1, 16'd100, 1'b0, ru, rs, ou, os);
        check_val("preset_const", longint'(ru), 148);

        // unsigned saturation
        for (int i = 0; i < 16; i++) load_word(i, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_op("usat", 16, 1'b0, 16'd0, 1'b0, ru, rs, ou, os);
        check_val("usat_const", longint'(ru), 65535);
        check_val("usat_const_ovf", longint'(ou), 1);

        // signed saturation at the negative limit
        for (int i = 0; i < 16; i++) load_word(i, 8'h80, 8'h80, 8'h7F, 8'h7F);
        run_op("ssat", 16, 1'b0, 16'd0, 1'b0, ru, rs, ou, os);
        check_val("ssat_const", longint'(rs), 32768);
        check_val("ssat_const_ovf", longint'(os), 1);

        // randomized operations, lengths 0..31 cover zero and clamping
        for (int t = 0; t < 12; t++) begin
            if (t % 3 == 0) rand_fill((t % 2) ? 255 : 15);
            run_op("rand", int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   16'($urandom), 1'b0, ru, rs, ou, os);
        end

        // start/load pulsed while busy must be ignored
        rand_fill(15);
        run_op("perturb", 16, 1'b0, 16'd0, 1'b1, ru, rs, ou, os);
        run_op("bank_word0", 1, 1'b1, 16'd5, 1'b0, ru, rs, ou, os);

        // reset in the middle of a run
        @(negedge clk);
        bus_u.start = 1'b1; bus_u.len = 5'd16; bus_u.acc_mode = 1'b0;
        @(posedge clk);
        #1;
        bus_u.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy",     longint'(bus_u.busy), 0);
        check_val("midrst_done",     longint'(bus_u.done), 0);
        check_val("midrst_result",   longint'(bus_u.result), 0);
        check_val("midrst_state",    longint'(bus_u.state), 0);
        check_val("midrst_overflow", longint'(bus_u.overflow), 0);
        check_val("midrst_busy_s",   longint'(bus_s.busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus_u.done || bus_s.done) seen++;
        end
        check_val("midrst_no_done", seen, 0);

        run_op("post_reset", 0, 1'b1, 16'd7, 1'b0, ru, rs, ou, os);
        check_val("post_reset_const", longint'(ru), 7);
        run_op("bank_kept", 16, 1'b0, 16'd0, 1'b0, ru, rs, ou, os);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
